mem_port_arbiter: RTL and testbench

//  Shares the single-ported unified memory between the FETCH stage (instruction reads) and the MEM stage
//  (data loads/stores) of the multicycle core. Each side issues a req/ack transaction; the arbiter picks
//  one winner round-robin, runs one variable-latency memory access, and returns data/ack to that side.
//  A per-access timeout guarantees the core never hangs on a memory that fails to assert ready.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core-side requesters, the arbiter and the memory.
// slave: arbiter view (fetch/data requests and memory response in).
// master: environment view (drives requests, answers memory accesses).
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;
    logic [DW-1:0] f_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ready;
    logic          err;
    logic          busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        input  m_rdata, m_ready,
        output f_ack, f_rdata, d_ack, d_rdata,
        output m_en, m_we, m_addr, m_wdata, err, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
        output m_rdata, m_ready,
        input  f_ack, f_rdata, d_ack, d_rdata,
        input  m_en, m_we, m_addr, m_wdata, err, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data sides.
// Ports: clk, rst (sync, active high), bus (slave modport of mem_port_arbiter_if).
module mem_port_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {SIDE_FETCH, SIDE_DATA} side_t;

    state_t        state, state_n;
    side_t         last_grant, last_grant_n;
    side_t         owner, owner_n;
    side_t         grant;
    logic [CW-1:0] cnt, cnt_n;

    logic          f_ack_q, f_ack_n;
    logic          d_ack_q, d_ack_n;
    logic          err_q, err_n;
    logic          busy_q, busy_n;
    logic          m_en_q, m_en_n;
    logic          m_we_q, m_we_n;
    logic [AW-1:0] m_addr_q, m_addr_n;
    logic [DW-1:0] m_wdata_q, m_wdata_n;
    logic [DW-1:0] f_rdata_q, f_rdata_n;
    logic [DW-1:0] d_rdata_q, d_rdata_n;

    assign bus.f_ack   = f_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.m_en    = m_en_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.f_rdata = f_rdata_q;
    assign bus.d_rdata = d_rdata_q;

    // On a tie the side that did not win last time goes next.
    always_comb begin
        grant = SIDE_FETCH;
        if (bus.f_req && bus.d_req) begin
            grant = (last_grant == SIDE_DATA) ? SIDE_FETCH : SIDE_DATA;
        end else if (bus.d_req) begin
            grant = SIDE_DATA;
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        owner_n      = owner;
        cnt_n        = cnt;
        f_ack_n      = 1'b0;
        d_ack_n      = 1'b0;
        err_n        = 1'b0;
        m_en_n       = m_en_q;
        m_we_n       = m_we_q;
        m_addr_n     = m_addr_q;
        m_wdata_n    = m_wdata_q;
        f_rdata_n    = f_rdata_q;
        d_rdata_n    = d_rdata_q;

        unique case (state)
            IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    state_n      = ACCESS;
                    owner_n      = grant;
                    last_grant_n = grant;
                    m_en_n       = 1'b1;
                    cnt_n        = '0;
                    if (grant == SIDE_DATA) begin
                        m_we_n    = bus.d_we;
                        m_addr_n  = bus.d_addr;
                        m_wdata_n = bus.d_wdata;
                    end else begin
                        m_we_n    = 1'b0;
                        m_addr_n  = bus.f_addr;
                        m_wdata_n = '0;
                    end
                end
            end
            ACCESS: begin
                // A ready on the last allowed cycle still counts as success.
                if (bus.m_ready || cnt == CW'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    m_en_n  = 1'b0;
                    m_we_n  = 1'b0;
                    err_n   = !bus.m_ready;
                    if (owner == SIDE_DATA) begin
                        d_ack_n = 1'b1;
                    end else begin
                        f_ack_n = 1'b1;
                    end
                    if (bus.m_ready && !m_we_q) begin
                        if (owner == SIDE_DATA) begin
                            d_rdata_n = bus.m_rdata;
                        end else begin
                            f_rdata_n = bus.m_rdata;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SIDE_DATA;
            owner      <= SIDE_FETCH;
            cnt        <= '0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            owner      <= owner_n;
            cnt        <= cnt_n;
            f_ack_q    <= f_ack_n;
            d_ack_q    <= d_ack_n;
            err_q      <= err_n;
            busy_q     <= busy_n;
            m_en_q     <= m_en_n;
            m_we_q     <= m_we_n;
            m_addr_q   <= m_addr_n;
            m_wdata_q  <= m_wdata_n;
            f_rdata_q  <= f_rdata_n;
            d_rdata_q  <= d_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: transaction-level model
// predicts grant order, ack cycle, err and read data for two requesters.
module tb_mem_port_arbiter;
    localparam int AW      = 8;
    localparam int DW      = 16;
    localparam int TIMEOUT = 16;
    localparam int NTX     = 20;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } req_t;

    typedef struct {
        logic          side;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            ack_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    req_t          fq[$];
    req_t          dq[$];
    int            waits[$];
    exp_t          sb[$];
    logic [DW-1:0] rmem [0:255];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            base = 0;
    bit            resp_on = 1'b0;
    bit            mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail(string name, string got, string req);
        total++;
        bad++;
        $display("FAIL %s: got %s required %s (cycle %0d)", name, got, req, cyc);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_m_en"}, 32'(bus.m_en), 0);
        check({tag, "_m_we"}, 32'(bus.m_we), 0);
        check({tag, "_m_addr"}, 32'(bus.m_addr), 0);
        check({tag, "_m_wdata"}, 32'(bus.m_wdata), 0);
        check({tag, "_f_ack"}, 32'(bus.f_ack), 0);
        check({tag, "_d_ack"}, 32'(bus.d_ack), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_f_rdata"}, 32'(bus.f_rdata), 0);
        check({tag, "_d_rdata"}, 32'(bus.d_rdata), 0);
    endtask

    // Transaction-level reference: each side's request becomes visible at
    // some edge; the arbiter, when free, serves whichever is visible, the
    // non-last side on a tie. An access with wait w takes min(w+1,TIMEOUT)
    // cycles, then one response cycle, then one idle cycle before the next grant.
    task automatic build_model();
        logic [DW-1:0] mm [0:255];
        logic [DW-1:0] fr;
        logic [DW-1:0] dr;
        int fi, di, k, free_e, fav, dav;
        bit last_data;
        mm = rmem;
        fr = '0;
        dr = '0;
        fi = 0;
        di = 0;
        k = 0;
        free_e = base;
        fav = base;
        dav = base;
        last_data = 1'b1;
        while (fi < NTX || di < NTX) begin
            int t, w, a;
            bit f_ok, d_ok, take_d;
            exp_t e;
            req_t r;
            t = free_e;
            if (fi < NTX && di < NTX) begin
                if (fav > t && dav > t) t = (fav < dav) ? fav : dav;
            end else if (fi < NTX) begin
                if (fav > t) t = fav;
            end else begin
                if (dav > t) t = dav;
            end
            f_ok = (fi < NTX) && (fav <= t);
            d_ok = (di < NTX) && (dav <= t);
            take_d = (f_ok && d_ok) ? !last_data : d_ok;
            last_data = take_d;
            w = waits[k];
            k++;
            a = (w < TIMEOUT) ? w + 1 : TIMEOUT;
            e.err = (w >= TIMEOUT);
            e.side = take_d;
            e.ack_edge = t + a;
            if (take_d) begin
                r = dq[di];
                di++;
                e.addr = r.addr;
                e.we = r.we;
                e.wdata = r.wdata;
                if (!e.err) begin
                    if (r.we) mm[r.addr] = r.wdata;
                    else dr = mm[r.addr];
                end
                e.rdata = dr;
                dav = t + a + 2 + r.gap;
            end else begin
                r = fq[fi];
                fi++;
                e.addr = r.addr;
                e.we = 1'b0;
                e.wdata = '0;
                if (!e.err) fr = mm[r.addr];
                e.rdata = fr;
                fav = t + a + 2 + r.gap;
            end
            sb.push_back(e);
            free_e = t + a + 2;
        end
    endtask

    task automatic run_fetch();
        int n;
        while (cyc < base - 1) step();
        foreach (fq[i]) begin
            bus.f_req = 1'b1;
            bus.f_addr = fq[i].addr;
            n = 0;
            do begin
                step();
                n++;
            end while (!bus.f_ack && n < 400);
            if (!bus.f_ack) begin
                fail("fetch_ack_wait", "no f_ack", "f_ack within 400 cycles");
                bus.f_req = 1'b0;
                return;
            end
            step();
            bus.f_req = 1'b0;
            repeat (fq[i].gap) step();
        end
    endtask

    task automatic run_data();
        int n;
        while (cyc < base - 1) step();
        foreach (dq[i]) begin
            bus.d_req = 1'b1;
            bus.d_we = dq[i].we;
            bus.d_addr = dq[i].addr;
            bus.d_wdata = dq[i].wdata;
            n = 0;
            do begin
                step();
                n++;
            end while (!bus.d_ack && n < 400);
            if (!bus.d_ack) begin
                fail("data_ack_wait", "no d_ack", "d_ack within 400 cycles");
                bus.d_req = 1'b0;
                return;
            end
            step();
            bus.d_req = 1'b0;
            repeat (dq[i].gap) step();
        end
    endtask

    // Memory: answers the n-th access after waits[n] cycles; waits >= TIMEOUT
    // never answer. Outside an access m_ready toggles randomly.
    initial begin : responder
        bit in_acc;
        int k;
        int w;
        in_acc = 1'b0;
        k = 0;
        w = 0;
        forever begin
            step();
            if (!resp_on) continue;
            if (bus.m_en) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    k = 0;
                    w = (waits.size() > 0) ? waits.pop_front() : TIMEOUT;
                end
                if (k == w) begin
                    bus.m_ready = 1'b1;
                    bus.m_rdata = rmem[bus.m_addr];
                    if (bus.m_we) rmem[bus.m_addr] = bus.m_wdata;
                end else begin
                    bus.m_ready = 1'b0;
                    bus.m_rdata = DW'($urandom);
                end
                k++;
            end else begin
                in_acc = 1'b0;
                bus.m_ready = 1'($urandom_range(0, 1));
                bus.m_rdata = DW'($urandom);
            end
        end
    end

    initial begin : monitor
        bit prev_en;
        exp_t e;
        prev_en = 1'b0;
        forever begin
            step();
            if (mon_on) begin
                if (bus.f_ack && bus.d_ack)
                    fail("dual_ack", "f_ack=1 d_ack=1", "at most one ack");
                if (bus.m_en && !bus.busy)
                    fail("busy_in_access", "busy=0", "busy=1");
                if (bus.m_en && !prev_en) begin
                    if (sb.size() == 0) begin
                        fail("access_start", "extra access", "none expected");
                    end else begin
                        check("acc_addr", 32'(bus.m_addr), 32'(sb[0].addr));
                        check("acc_we", 32'(bus.m_we), 32'(sb[0].we));
                        if (sb[0].we)
                            check("acc_wdata", 32'(bus.m_wdata), 32'(sb[0].wdata));
                    end
                end
                if (bus.f_ack || bus.d_ack) begin
                    if (sb.size() == 0) begin
                        fail("ack", "extra ack", "none expected");
                    end else begin
                        e = sb.pop_front();
                        check("ack_side", 32'(bus.d_ack), 32'(e.side));
                        check("ack_cycle", 32'(cyc), 32'(e.ack_edge));
                        check("ack_err", 32'(bus.err), 32'(e.err));
                        if (e.side)
                            check("d_rdata", 32'(bus.d_rdata), 32'(e.rdata));
                        else
                            check("f_rdata", 32'(bus.f_rdata), 32'(e.rdata));
                    end
                end else if (bus.err) begin
                    fail("err_outside_ack", "err=1", "err=0");
                end
            end
            prev_en = bus.m_en;
        end
    end

    initial begin : main
        req_t r;
        int   sel;
        bus.f_req = 1'b0;
        bus.f_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;
        bus.m_ready = 1'b0;
        bus.m_rdata = '0;

        rst = 1'b1;
        repeat (2) step();
        check_zero("reset");
        rst = 1'b0;

        // Reset in the middle of a stalled access.
        bus.f_req = 1'b1;
        bus.f_addr = 8'h33;
        step();
        check("t1_m_en", 32'(bus.m_en), 1);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_m_addr", 32'(bus.m_addr), 32'h33);
        repeat (2) step();
        rst = 1'b1;
        bus.f_req = 1'b0;
        step();
        check_zero("t1_rst1");
        step();
        check_zero("t1_rst2");
        rst = 1'b0;
        step();
        check_zero("t1_idle");

        for (int i = 0; i < 256; i++) rmem[i] = DW'($urandom);
        rmem[8'h10] = 16'hBEEF;

        r.we = 1'b0;
        r.addr = 8'h10;
        r.wdata = '0;
        r.gap = 0;
        fq.push_back(r);
        r.we = 1'b1;
        r.addr = 8'h20;
        r.wdata = 16'h1234;
        dq.push_back(r);
        for (int i = 1; i < NTX; i++) begin
            r.we = 1'b0;
            r.addr = AW'($urandom_range(16, 31));
            r.wdata = '0;
            r.gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            fq.push_back(r);
            r.we = 1'($urandom_range(0, 1));
            r.addr = AW'($urandom_range(16, 39));
            r.wdata = DW'($urandom);
            r.gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            dq.push_back(r);
        end

        // Grant order under contention is fetch, data, fetch, data: first
        // fetch immediate, store after 3 waits, fetch times out, then a
        // data access answered on its last allowed cycle.
        waits.push_back(0);
        waits.push_back(3);
        waits.push_back(TIMEOUT);
        waits.push_back(TIMEOUT - 1);
        for (int i = 4; i < 2 * NTX; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) waits.push_back(0);
            else if (sel < 7) waits.push_back($urandom_range(1, 4));
            else if (sel == 7) waits.push_back($urandom_range(5, TIMEOUT - 2));
            else if (sel == 8) waits.push_back(TIMEOUT - 1);
            else waits.push_back(TIMEOUT);
        end

        base = cyc + 2;
        build_model();
        mon_on = 1'b1;
        resp_on = 1'b1;

        fork
            run_fetch();
            run_data();
        join

        repeat (5) step();
        check("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
